// File: rtl/canny_frame_ctrl_pkg.sv
// Shared definitions for the Canny frame sequencer: FSM states and window tag layout.
package canny_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int TAG_W   = 4;
   localparam int TAG_V   = 0;
   localparam int TAG_SOF = 1;
   localparam int TAG_EOL = 2;
   localparam int TAG_EOF = 3;

   function automatic logic [TAG_W-1:0] make_tag(input logic v, input logic sof,
                                                 input logic eol, input logic eof);
      logic [TAG_W-1:0] t;
      t          = '0;
      t[TAG_V]   = v;
      t[TAG_SOF] = sof;
      t[TAG_EOL] = eol;
      t[TAG_EOF] = eof;
      return t;
   endfunction

endpackage

// File: rtl/canny_frame_ctrl_tag_pipe.sv
// Enable-gated tag delay line; the tag leaving on a beat is held on tag_out for one cycle.
module frame_tag_pipe #(
   parameter int DEPTH = 2,
   parameter int TW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic [TW-1:0] tag_in,
   output logic [TW-1:0] tag_out
);

   logic [TW-1:0] stage [DEPTH];

   // NOTE: the stage array is reset like ordinary flops so stale tags never leak into a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         tag_out <= '0;
      end else if (clr) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
         tag_out <= '0;
      end else begin
         // NOTE: non-blocking updates let every stage read its neighbour's pre-edge value.
         tag_out <= en ? stage[DEPTH-1] : '0;
         if (en) begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
         end
      end
   end

endmodule

// File: rtl/canny_frame_ctrl.sv
// Frame sequencer for the 3x3 line buffers: handshake, raster counters, window tagging, flush.
module canny_frame_ctrl
   import canny_frame_ctrl_pkg::*;
#(
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int W        = 8,
   parameter int PIPE_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic         in_valid,
   input  logic [W-1:0] in_pixel,
   output logic         in_ready,
   output logic         lb_en,
   output logic [W-1:0] lb_pixel,
   output logic         win_valid,
   output logic         win_sof,
   output logic         win_eol,
   output logic         win_eof,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(PIPE_LAT + 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [FW-1:0]    flush_cnt;
   logic             accept, line_end, at_last, in_frame, tag_v;
   logic [TAG_W-1:0] tag_in, tag_out;

   assign in_ready = (state == ST_FILL) || (state == ST_RUN);
   assign accept   = in_valid & in_ready;
   assign lb_en    = accept | (state == ST_FLUSH);
   assign lb_pixel = accept ? in_pixel : '0;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);
   assign in_frame = busy && !abort;

   assign line_end = (col == CW'(IMG_W - 1));
   assign at_last  = line_end && (row == RW'(IMG_H - 1));
   assign tag_v    = (row >= RW'(2)) && (col >= CW'(2));
   assign tag_in   = accept ? make_tag(tag_v, (row == RW'(2)) && (col == CW'(2)),
                                       tag_v && line_end, at_last)
                            : '0;

   // NOTE: next state gets a default first so no path through the case infers a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start && !abort) state_nxt = ST_FILL;
         ST_FILL:  if (accept && (row == RW'(2)) && (col == '0)) state_nxt = ST_RUN;
         ST_RUN:   if (accept && at_last) state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush_cnt == FW'(PIPE_LAT - 1)) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (abort && busy) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Counters restart from zero whenever the sequencer is idle or a frame is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row       <= '0;
         col       <= '0;
         flush_cnt <= '0;
      end else if (!in_frame) begin
         row       <= '0;
         col       <= '0;
         flush_cnt <= '0;
      end else begin
         if (accept) begin
            if (line_end) begin
               col <= '0;
               if (row != RW'(IMG_H - 1)) row <= row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
         if (state == ST_FLUSH) flush_cnt <= flush_cnt + FW'(1);
      end
   end

   frame_tag_pipe #(
      .DEPTH(PIPE_LAT),
      .TW   (TAG_W)
   ) u_tag_pipe (
      .clk    (clk),
      .rst    (rst),
      .en     (lb_en),
      .clr    (abort && busy),
      .tag_in (tag_in),
      .tag_out(tag_out)
   );

   assign win_valid = tag_out[TAG_V];
   assign win_sof   = tag_out[TAG_SOF];
   assign win_eol   = tag_out[TAG_EOL];
   assign win_eof   = tag_out[TAG_EOF];

endmodule
